// File: rtl/i2c_codec_target.sv
// I2C target for the codec register-write protocol.
// Frame: START, {dev_addr[6:0], rw}, byte1, byte2, STOP.
// A completed write sets reg_addr = byte1[7:1] and reg_data = {byte1[0], byte2},
// and pulses wr_valid for one clk. Reads and foreign addresses are NACKed.
//
// Ports:
//   clk       system clock, all logic on posedge
//   reset     synchronous, active-high
//   scl       I2C clock from the master (asynchronous)
//   sda_in    SDA as seen on the bus (asynchronous)
//   sda_oe    1 = pull SDA low (ACK), 0 = release; never drives high
//   reg_addr  register address of the last completed write
//   reg_data  register value of the last completed write
//   wr_valid  one-clk pulse when reg_addr/reg_data update
//   busy      high from START until STOP or abort
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | bus ignored until START
// ADDR      | shifting {addr, rw}
// ACK_A     | ACKing the device address
// BYTE1     | shifting byte1 (reg_addr, reg_data[8])
// ACK_1     | ACKing byte1
// BYTE2     | shifting byte2 (reg_data[7:0])
// ACK_2     | ACKing byte2, write already committed
// WAIT_STOP | SDA released, only START/STOP leave
module i2c_codec_target #(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         MIN_HALF = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [6:0] reg_addr,
    output logic [8:0] reg_data,
    output logic       wr_valid,
    output logic       busy
);

    // Event detection lags the pins by 3 clk, so SCL halves must be longer.
    generate
        if (MIN_HALF < 4) begin : g_min_half_chk
            $error("MIN_HALF must be at least 4 clk cycles");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, WAIT_STOP
    } state_t;

    state_t     state, state_nx;
    logic [3:0] bit_cnt, bit_cnt_nx;
    logic [7:0] shift_q, shift_nx;
    logic [7:0] byte1_q, byte1_nx;
    logic       sda_oe_nx;
    logic [6:0] reg_addr_nx;
    logic [8:0] reg_data_nx;
    logic       wr_valid_nx;

    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;

    logic scl_rise, scl_fall, start_det, stop_det, in_data;

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    // SCL must be high in both samples so an SCL edge is never mistaken for START/STOP.
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign in_data   = (state == ADDR) || (state == BYTE1) || (state == BYTE2);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1   <= 1'b1;
            scl_s2   <= 1'b1;
            scl_d    <= 1'b1;
            sda_s1   <= 1'b1;
            sda_s2   <= 1'b1;
            sda_d    <= 1'b1;
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            shift_q  <= 8'd0;
            byte1_q  <= 8'd0;
            sda_oe   <= 1'b0;
            reg_addr <= 7'd0;
            reg_data <= 9'd0;
            wr_valid <= 1'b0;
        end else begin
            scl_s1   <= scl;
            scl_s2   <= scl_s1;
            scl_d    <= scl_s2;
            sda_s1   <= sda_in;
            sda_s2   <= sda_s1;
            sda_d    <= sda_s2;
            state    <= state_nx;
            bit_cnt  <= bit_cnt_nx;
            shift_q  <= shift_nx;
            byte1_q  <= byte1_nx;
            sda_oe   <= sda_oe_nx;
            reg_addr <= reg_addr_nx;
            reg_data <= reg_data_nx;
            wr_valid <= wr_valid_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        bit_cnt_nx  = bit_cnt;
        shift_nx    = shift_q;
        byte1_nx    = byte1_q;
        sda_oe_nx   = sda_oe;
        reg_addr_nx = reg_addr;
        reg_data_nx = reg_data;
        wr_valid_nx = 1'b0;

        if (start_det) begin
            state_nx   = ADDR;
            bit_cnt_nx = 4'd0;
            sda_oe_nx  = 1'b0;
        end else if (stop_det) begin
            state_nx   = IDLE;
            bit_cnt_nx = 4'd0;
            sda_oe_nx  = 1'b0;
        end else if (scl_rise) begin
            if (in_data && (bit_cnt < 4'd8)) begin
                shift_nx   = {shift_q[6:0], sda_s2};
                bit_cnt_nx = bit_cnt + 4'd1;
            end
        end else if (scl_fall) begin
            // The falling edge right after START leaves bit_cnt at 0, so it is a no-op.
            case (state)
                ADDR: begin
                    if (bit_cnt == 4'd8) begin
                        bit_cnt_nx = 4'd0;
                        if ((shift_q[7:1] == DEV_ADDR) && !shift_q[0]) begin
                            state_nx  = ACK_A;
                            sda_oe_nx = 1'b1;
                        end else begin
                            state_nx  = WAIT_STOP;
                        end
                    end
                end
                ACK_A: begin
                    sda_oe_nx = 1'b0;
                    state_nx  = BYTE1;
                end
                BYTE1: begin
                    if (bit_cnt == 4'd8) begin
                        bit_cnt_nx = 4'd0;
                        byte1_nx   = shift_q;
                        sda_oe_nx  = 1'b1;
                        state_nx   = ACK_1;
                    end
                end
                ACK_1: begin
                    sda_oe_nx = 1'b0;
                    state_nx  = BYTE2;
                end
                BYTE2: begin
                    if (bit_cnt == 4'd8) begin
                        bit_cnt_nx  = 4'd0;
                        reg_addr_nx = byte1_q[7:1];
                        reg_data_nx = {byte1_q[0], shift_q};
                        wr_valid_nx = 1'b1;
                        sda_oe_nx   = 1'b1;
                        state_nx    = ACK_2;
                    end
                end
                ACK_2: begin
                    sda_oe_nx = 1'b0;
                    state_nx  = WAIT_STOP;
                end
                default: begin
                    sda_oe_nx = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/i2c_codec_target.md
Name: i2c_codec_target

Overview:
- I2C target (responder) for the codec register-write protocol: 7-bit device address, then two data bytes carrying a 7-bit register address and 9-bit register value.
- Used as the codec-side model in simulation and as an on-chip target, so the audio setup master can be exercised end to end.
- Oversamples SCL/SDA on the system clock, detects START/STOP, ACKs valid writes, and emits a one-cycle register-write strobe.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit I2C device address this target answers to.
- MIN_HALF, 4, minimum SCL high/low time in clk cycles; shorter pulses are unsupported.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- scl  in  1  I2C clock from master (asynchronous).
- sda_in  in  1  I2C data line as seen on the bus (asynchronous).
- sda_oe  out  1  1 = pull SDA low (ACK); 0 = release. Open-drain; never drives high.
- reg_addr  out  7  register address of last completed write.
- reg_data  out  9  register value of last completed write.
- wr_valid  out  1  one-clk pulse when reg_addr/reg_data update.
- busy  out  1  high from START until STOP or abort.

Behaviour:
- Reset (synchronous, active-high): sda_oe=0, reg_addr=0, reg_data=0, wr_valid=0, busy=0, state=IDLE, bit counter=0, shift register=0, synchronizers preset to 1 (idle bus).
- Reset mid-transaction: drop sda_oe on the same edge and return to IDLE. Do not pulse wr_valid. Ignore the bus until the next START.
- Input conditioning: 2-FF synchronizer on scl and sda_in, plus one delayed copy each for edge detection. Event latency is 3 clk from a pin change.
- START = SDA falling while SCL high. STOP = SDA rising while SCL high. Both are detected in every state, including ACK phases.
- START in any state (including repeated START): enter ADDR, bit counter=0, sda_oe=0, busy=1.
- STOP in any state: enter IDLE, sda_oe=0, busy=0. No write commit.
- Data bits are sampled on the synchronized SCL rising edge, MSB first, into an 8-bit shift register.
- ACK timing: sda_oe asserts on the SCL falling edge after the 8th bit. It releases on the next SCL falling edge, after the 9th clock.
- States:
  - IDLE: wait for START.
  - ADDR: 8 bits = {addr[6:0], rw}. After the 8th bit:
    - addr==DEV_ADDR and rw==0: go to ACK_A.
    - Otherwise (mismatch or rw=1 read, since reads are unsupported): go to WAIT_STOP with no ACK, so SDA stays released and the master sees a NACK.
  - ACK_A: hold ACK for one SCL clock, then go to BYTE1.
  - BYTE1: 8 bits; latch byte1 internally, then go to ACK_1.
  - ACK_1: ACK, then go to BYTE2.
  - BYTE2: 8 bits. On the SCL falling edge that starts ACK_2:
    - reg_addr = byte1[7:1]
    - reg_data = {byte1[0], byte2}
    - wr_valid = 1 for exactly one clk
    - go to ACK_2.
  - ACK_2: ACK, then go to WAIT_STOP.
  - WAIT_STOP: release SDA and NACK any further bytes. Only STOP or START exits this state.
- reg_addr/reg_data hold their value between writes and change only on a wr_valid cycle.
- A STOP or START before the BYTE2 commit aborts the transaction; outputs are unchanged.
- SDA changes while SCL is high in data states are treated as START/STOP. No glitch filtering beyond the synchronizer.
- busy: 1 in every state except IDLE.

Test Plan:
- Write reg 0x04 data 0x1D2: bytes 0x34, 0x09, 0xD2, then STOP -> ACK after each byte. wr_valid pulses once with reg_addr=0x04, reg_data=0x1D2. busy falls 3 clk after STOP.
- Address mismatch, byte 0x36 (addr 0x1B) -> sda_oe stays 0 for the whole transfer. No wr_valid. Outputs unchanged.
- Read request, byte 0x35 -> NACK (sda_oe=0 on the 9th clock). No wr_valid. The next START plus valid write (reg 0x0F, data 0x000) commits normally.
- STOP after 0x34, 0x1E -> two ACKs. No wr_valid. reg_addr/reg_data keep their previous values.
- Repeated START mid-BYTE1 (after 4 bits), then full write reg 0x07 data 0x00A -> single wr_valid with 0x07/0x00A.
- reset asserted during BYTE2 while sda_oe=0, and asserted during ACK_1 while sda_oe=1 -> sda_oe=0 and state IDLE on the next clk. No wr_valid. A subsequent full write succeeds.
